pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//   Fetch-side controller that owns the program counter and sequences instruction fetch.
//   Issues one instruction-memory request at a time over a req/ready handshake.
//   Presents each fetched instruction to decode over a valid/ready handshake.
//   Applies next-PC selection, with priority trap > redirect > sequential +4, plus halt control.
// PARAMETERS
//   RESET_VECTOR  32'h0000_0000  PC loaded on reset
//   TRAP_VECTOR   32'h0000_0100  PC loaded on trap or misaligned redirect
// PORTS
//   clk             in   1   clock, rising edge
//   rst             in   1   asynchronous, active-high reset
//   imem_req        out  1   fetch request; held until imem_ready
//   imem_addr       out  32  fetch address (= pc); stable while imem_req=1
//   imem_ready      in   1   memory accepts request and returns imem_rdata this cycle
//   imem_rdata      in   32  instruction word, valid when imem_req & imem_ready
//   instr_valid     out  1   instr/instr_pc valid to decode
//   instr           out  32  fetched instruction
//   instr_pc        out  32  address of instr
//   decode_ready    in   1   decode consumes instr when instr_valid & decode_ready
//   redirect_valid  in   1   branch/jump taken (1-cycle pulse)
//   redirect_pc     in   32  redirect target
//   trap            in   1   exception/interrupt (1-cycle pulse)
//   halt            in   1   stop fetching after current instruction
//   misalign_err    out  1   1-cycle pulse: redirect target[1:0]!=0
//   halted          out  1   high while in HALTED
// BEHAVIOUR
//   Reset (async): state=BOOT, pc=RESET_VECTOR; all other outputs 0.
//   States:
//   - BOOT: imem_req=0; next cycle -> FETCH (one dead cycle after reset release).
//   - FETCH: imem_req=1, imem_addr=pc.
//     - On imem_ready with no kill pending: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, -> HOLD.
//     - On imem_ready with kill pending or a same-cycle trap/redirect: discard data, pc<=target, clear kill, stay FETCH.
//     - New address is presented next cycle.
//   - HOLD: imem_req=0, instr_valid=1, outputs stable.
//     - decode_ready=1: instr_valid<=0; -> HALTED if halt=1, else FETCH.
//   - HALTED: imem_req=0, instr_valid=0, halted=1. Exits only on trap/redirect: pc<=target, -> FETCH.
//   Trap/redirect handling:
//   - Target is TRAP_VECTOR for trap, redirect_pc for redirect.
//   - In HOLD: flush (instr_valid<=0, instr not consumed), pc<=target, -> FETCH.
//   - In FETCH without imem_ready: imem_addr must stay stable, so latch the target and set kill; request completes and is discarded.
//   - Kill already pending: a higher-or-equal priority event overwrites the latched target; a lower-priority one is dropped.
//   - In BOOT: pc<=target, -> FETCH.
//   Priority and boundaries:
//   - trap and redirect_valid in the same cycle: trap wins, redirect ignored.
//   - redirect_pc[1:0]!=0: misalign_err=1 next cycle; treated as trap (target=TRAP_VECTOR).
//   - Misaligned redirect together with trap: single trap, misalign_err still pulses.
//   - halt in BOOT/FETCH is sampled and held as a pending flag; it takes effect on the next HOLD handshake.
//   - pc arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 -> 32'h0.
//   - rst mid-fetch: imem_req drops immediately; in-flight response is ignored.
//   Latency: imem_ready to instr_valid = 1 cycle; best case one instruction per 2 cycles.
// TESTING
//   T1 reset: rst 1->0, imem_ready=1 -> imem_req at cycle 2 with addr 0; instr_pc 0,4,8 on successive handshakes.
//   T2 stall: hold decode_ready=0 for 5 cycles -> instr/instr_pc stable, imem_req=0, no pc advance.
//   T3 redirect mid-fetch: redirect to 0x40 while FETCH waits 3 cycles -> addr stays, response discarded, next fetch 0x40.
//   T4 trap+redirect same cycle: redirect 0x80, trap=1 -> next fetch 0x100; redirect 0x82 alone -> misalign_err pulse, fetch 0x100.
//   T5 halt/wrap: pc=0xFFFFFFFC, halt=1 -> instr_pc 0xFFFFFFFC consumed, halted=1; redirect 0x20 -> FETCH 0x20.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// ------------------------------------------------------------------
// pc_sequencer_if : fetch, decode and control signals of pc_sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap;
  logic        halt;
  logic        misalign_err;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err, halted,
    input  imem_ready, imem_rdata, decode_ready, redirect_valid, redirect_pc, trap, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err, halted,
    output imem_ready, imem_rdata, decode_ready, redirect_valid, redirect_pc, trap, halt
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ------------------------------------------------------------------
// pc_sequencer : owns the PC, issues one fetch at a time, hands instructions to decode
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input wire             clk,
  input wire             rst,
  pc_sequencer_if.master bus
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        kill_q, kill_d;
  logic        kill_prio_q, kill_prio_d;
  logic [31:0] kill_pc_q, kill_pc_d;
  logic        halt_pend_q, halt_pend_d;
  logic        misalign_q, misalign_d;

  // Event priority: 1 = trap class (trap or misaligned redirect), 0 = plain redirect.
  logic        w_misaligned;
  logic        w_ev;
  logic        w_ev_prio;
  logic [31:0] w_ev_pc;
  logic        w_ev_wins;

  assign w_misaligned = (bus.redirect_pc[1:0] != 2'b00);
  assign w_ev         = bus.trap | bus.redirect_valid;
  assign w_ev_prio    = bus.trap | (bus.redirect_valid & w_misaligned);
  assign w_ev_pc      = w_ev_prio ? TRAP_VECTOR : bus.redirect_pc;
  assign w_ev_wins    = w_ev & (~kill_q | w_ev_prio | ~kill_prio_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      kill_q        <= 1'b0;
      kill_prio_q   <= 1'b0;
      kill_pc_q     <= 32'h0;
      halt_pend_q   <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      kill_q        <= kill_d;
      kill_prio_q   <= kill_prio_d;
      kill_pc_q     <= kill_pc_d;
      halt_pend_q   <= halt_pend_d;
      misalign_q    <= misalign_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    kill_d        = kill_q;
    kill_prio_d   = kill_prio_q;
    kill_pc_d     = kill_pc_q;
    halt_pend_d   = halt_pend_q;
    misalign_d    = bus.redirect_valid & w_misaligned;

    case (state_q)
      ST_BOOT: begin
        halt_pend_d = halt_pend_q | bus.halt;
        state_d     = ST_FETCH;
        if (w_ev) pc_d = w_ev_pc;
      end
      ST_FETCH: begin
        halt_pend_d = halt_pend_q | bus.halt;
        if (bus.imem_ready) begin
          if (kill_q || w_ev) begin
            pc_d   = w_ev_wins ? w_ev_pc : kill_pc_q;
            kill_d = 1'b0;
          end else begin
            instr_d       = bus.imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
            state_d       = ST_HOLD;
          end
        end else if (w_ev_wins) begin
          // Address must stay stable, so park the target until the request completes.
          kill_d      = 1'b1;
          kill_pc_d   = w_ev_pc;
          kill_prio_d = w_ev_prio;
        end
      end
      ST_HOLD: begin
        if (w_ev) begin
          instr_valid_d = 1'b0;
          pc_d          = w_ev_pc;
          state_d       = ST_FETCH;
        end else if (bus.decode_ready) begin
          instr_valid_d = 1'b0;
          if (bus.halt || halt_pend_q) begin
            halt_pend_d = 1'b0;
            state_d     = ST_HALTED;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALTED: begin
        if (w_ev) begin
          pc_d    = w_ev_pc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    bus.imem_req = (state_q == ST_FETCH);
    bus.halted   = (state_q == ST_HALTED);
  end

  assign bus.imem_addr    = pc_q;
  assign bus.instr_valid  = instr_valid_q;
  assign bus.instr        = instr_q;
  assign bus.instr_pc     = instr_pc_q;
  assign bus.misalign_err = misalign_q;

endmodule

`default_nettype wire
